addr8u_inverse_serial: RTL and testbench

ADDR8U_INVERSE_SERIAL -- requirements
Module: addr8u_inverse_serial

---
 rtl/addr8u_inverse_serial.sv | 113 +++++++++++
 tb/tb_addr8u_inverse_serial.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addr8u_inverse_serial.sv
// Bit-serial inverse of an 8-bit unsigned adder: recovers A = S - B.
// Ports: clk, rst_n, s_i[8:0], b_i[7:0], in_valid/in_ready,
// a_o[7:0], err_o, out_valid/out_ready, err_cnt_o[7:0].
module addr8u_inverse_serial (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] s_i,
   input  logic [7:0] b_i,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] a_o,
   output logic       err_o,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] err_cnt_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0] state_q, state_d;
   logic [8:0] s_q, s_d;
   logic [8:0] b_q, b_d;
   logic [8:0] d_q, d_d;
   logic [3:0] cnt_q, cnt_d;
   logic       borrow_q, borrow_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   logic       sk, bk, dk, bnext;
   logic       done, err_res;

   assign sk    = s_q[0];
   assign bk    = b_q[0];
   assign dk    = sk ^ bk ^ borrow_q;
   assign bnext = (~sk & (bk | borrow_q)) | (sk & bk & borrow_q);

   assign done    = (state_q == ST_DONE);
   // A borrow out means S < B; a set top bit means S - B > 255.
   assign err_res = d_q[8] | borrow_q;

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      b_d       = b_q;
      d_d       = d_q;
      cnt_d     = cnt_q;
      borrow_d  = borrow_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               s_d      = s_i;
               b_d      = {1'b0, b_i};
               d_d      = '0;
               cnt_d    = '0;
               borrow_d = 1'b0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            // Operands shift out LSB first; difference bits shift in at
            // the top so bit 0 lands in d_q[0] after nine steps.
            s_d      = {1'b0, s_q[8:1]};
            b_d      = {1'b0, b_q[8:1]};
            d_d      = {dk, d_q[8:1]};
            borrow_d = bnext;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd8) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
               if (err_res && (err_cnt_q != 8'hFF)) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         s_q       <= '0;
         b_q       <= '0;
         d_q       <= '0;
         cnt_q     <= '0;
         borrow_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         b_q       <= b_d;
         d_q       <= d_d;
         cnt_q     <= cnt_d;
         borrow_q  <= borrow_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = done;
   assign a_o       = done ? d_q[7:0] : 8'h00;
   assign err_o     = done & err_res;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_addr8u_inverse_serial.sv
// Scoreboard bench for addr8u_inverse_serial.
// Driver pushes expected results; monitor pops on output handshakes.
module tb_addr8u_inverse_serial;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] s_i = '0;
   logic [7:0] b_i = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a_o;
   logic       err_o;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] err_cnt_o;

   addr8u_inverse_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_i       (s_i),
      .b_i       (b_i),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_o       (a_o),
      .err_o     (err_o),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_cnt_o (err_cnt_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rdy_mode = 1;
   int model_cnt = 0;
   int exp_q[$];
   int acc_q[$];
   bit seen = 0;
   bit held = 0;
   bit post = 0;
   logic [7:0] last_a;
   logic       last_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name,
                      input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer subtraction.
   function automatic int model(input int s, input int b);
      int diff;
      int err;
      diff = s - b;
      err = (diff < 0 || diff > 255) ? 1 : 0;
      return (err << 8) | (diff & 255);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) out_ready = 1'($urandom_range(0, 1));
         else if (rdy_mode == 1) out_ready = 1'b1;
         else out_ready = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (post) begin
            chk(in_ready && !out_valid, "turnaround", in_ready, 1);
            post = 0;
         end
         if (out_valid) begin
            if (!seen) begin
               seen = 1;
               if (acc_q.size() > 0) begin
                  int a;
                  a = acc_q.pop_front();
                  chk(cyc - a == 9, "latency", cyc - a, 9);
               end else begin
                  chk(0, "unexpected_valid", 1, 0);
               end
            end
            if (held) begin
               chk(a_o == last_a && err_o == last_e, "hold",
                   {err_o, a_o}, {last_e, last_a});
            end
            if (out_ready) begin
               if (exp_q.size() > 0) begin
                  int e;
                  e = exp_q.pop_front();
                  chk(a_o == e[7:0], "a_o", a_o, e[7:0]);
                  chk(err_o == e[8], "err_o", err_o, e[8]);
                  chk(err_cnt_o == model_cnt, "err_cnt", err_cnt_o, model_cnt);
                  if (e[8] && model_cnt < 255) model_cnt++;
               end else begin
                  chk(0, "scoreboard_empty", 1, 0);
               end
               seen = 0;
               held = 0;
               post = 1;
            end else begin
               held = 1;
               last_a = a_o;
               last_e = err_o;
            end
         end
      end
   end

   task automatic issue(input logic [8:0] s, input logic [7:0] b,
                        input bit track);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) chk(0, "in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      s_i = s;
      b_i = b;
      if (track) exp_q.push_back(model(int'(s), int'(b)));
      @(posedge clk);
      #1;
      if (track) acc_q.push_back(cyc);
      in_valid = 1'b0;
      s_i = 9'($urandom);
      b_i = 8'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #22;
      chk(!out_valid && a_o == 0 && !err_o && err_cnt_o == 0,
          "reset_outputs", {out_valid, err_o, a_o}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk(in_ready, "reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      rdy_mode = 1;
      issue(9'h12C, 8'h64, 1);
      issue(9'h005, 8'h0A, 1);
      issue(9'h1FF, 8'h00, 1);
      issue(9'h1FE, 8'hFF, 1);
      drain();

      // Stall the consumer and poke the input side while DONE.
      rdy_mode = 2;
      @(posedge clk);
      #1;
      issue(9'h0AB, 8'h12, 1);
      begin
         int n;
         n = 0;
         while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk(out_valid, "stall_valid_timeout", out_valid, 1);
      end
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         s_i = 9'($urandom);
         b_i = 8'($urandom);
         chk(!in_ready && out_valid, "stall_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rdy_mode = 1;
      drain();

      // Abort a job mid-RUN.
      chk(err_cnt_o != 0, "pre_reset_cnt", err_cnt_o, 1);
      issue(9'h1AB, 8'h33, 0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_cnt = 0;
      acc_q.delete();
      seen = 0;
      held = 0;
      post = 0;
      #1;
      chk(!out_valid && a_o == 0 && !err_o && err_cnt_o == 0,
          "abort_outputs", {err_cnt_o, err_o, a_o}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         bit any;
         any = 0;
         for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) any = 1;
         end
         chk(!any, "abort_no_result", any, 0);
      end
      @(posedge clk);
      #1;
      issue(9'h0FF, 8'h0F, 1);
      drain();

      rdy_mode = 0;
      for (int i = 0; i < 150; i++) begin
         logic [8:0] s;
         logic [7:0] b;
         s = 9'($urandom);
         b = 8'($urandom);
         if (i % 10 == 0) s = {1'b0, b};
         if (i % 10 == 1) s = 9'({1'b0, b} + 9'd255);
         issue(s, b, 1);
      end
      drain();

      rdy_mode = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 260; i++) begin
         logic [7:0] b;
         b = 8'($urandom_range(1, 255));
         issue(9'(b - 8'd1), b, 1);
      end
      drain();
      chk(err_cnt_o == 8'hFF, "saturate", err_cnt_o, 255);
      chk(err_cnt_o == model_cnt, "final_cnt", err_cnt_o, model_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
